// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file debug arbiter.
//   XLEN        : register width
//   REG_ADDR_W  : register address width (32 registers)
//   state_t     : arbiter FSM state
//   dbg_req_t   : buffered debug request (write flag, address, write data)
package rf_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       wdata;
  } dbg_req_t;

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// regfile_dbg_arbiter
// Shares the 32x32 register file between a single-cycle core and a debug
// requester. The core's writeback port and rs1 read port normally pass
// straight through. A debug read steals the rs1 port for one cycle and
// stalls the core. A debug write waits for a cycle where the core does not
// write; after MAX_WAIT such waits it takes the port anyway and stalls the
// core for that one cycle.
//
// Parameters:
//   MAX_WAIT  cycles a pending debug write waits for an idle write port
//             before forcing a stall (must be >= 1).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   core_we/core_rd/core_wdata         core writeback request
//   core_rs1                           core rs1 read address
//   core_stall                         core must hold and replay this cycle
//   rf_we/rf_rd/rf_wdata/rf_rs1        register file port controls
//   rf_rdata1                          register file rs1 data (combinational)
//   dbg_req_valid/ready/write/addr/wdata  debug request channel
//   dbg_rsp_valid/ready/rdata          debug response channel (registered)
//   fsm_state                          current arbiter state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn by this block once raised and the
// response data stays stable until the transfer.
module regfile_dbg_arbiter
  import rf_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_we,
  input  logic [REG_ADDR_W-1:0] core_rd,
  input  logic [XLEN-1:0]       core_wdata,
  input  logic [REG_ADDR_W-1:0] core_rs1,
  output logic                  core_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [REG_ADDR_W-1:0] rf_rs1,
  input  logic [XLEN-1:0]       rf_rdata1,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [REG_ADDR_W-1:0] dbg_req_addr,
  input  logic [XLEN-1:0]       dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  input  logic                  dbg_rsp_ready,
  output logic [XLEN-1:0]       dbg_rsp_rdata,
  output state_t                fsm_state
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  state_t          state;
  dbg_req_t        req_buf;
  logic [CNT_W-1:0] wait_cnt;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;

  logic rd_steal;
  logic wr_grant;

  always_comb begin
    rd_steal = (state == PEND) && !req_buf.write;
    wr_grant = (state == PEND) && req_buf.write &&
               (!core_we || (wait_cnt == CNT_MAX));
  end

  // Port steering. Default is transparent pass-through of the core.
  always_comb begin
    rf_we         = core_we;
    rf_rd         = core_rd;
    rf_wdata      = core_wdata;
    rf_rs1        = core_rs1;
    core_stall    = 1'b0;
    dbg_req_ready = (state == IDLE);

    if (rd_steal) begin
      // The core is stalled and will replay, so its writeback in this cycle
      // is dropped; the debug read therefore sees the pre-write value.
      rf_rs1     = req_buf.addr;
      rf_we      = 1'b0;
      core_stall = 1'b1;
    end else if (wr_grant) begin
      rf_we      = 1'b1;
      rf_rd      = req_buf.addr;
      rf_wdata   = req_buf.wdata;
      // Only a forced grant collides with a core write; that write is
      // replaced by the debug write and replayed next cycle.
      core_stall = core_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_buf     <= '0;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_req_valid) begin
            req_buf.write <= dbg_req_write;
            req_buf.addr  <= dbg_req_addr;
            req_buf.wdata <= dbg_req_wdata;
            wait_cnt      <= '0;
            state         <= PEND;
          end
        end
        PEND: begin
          if (!req_buf.write) begin
            rsp_rdata_q <= rf_rdata1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (wr_grant) begin
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (dbg_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Bench for regfile_dbg_arbiter: a register file model sits on the rf_*
// port, a random core drives writebacks and rs1 reads and replays whatever
// instruction was stalled, and a golden register image tracks what the
// register file must contain according to the arbitration rules.
module tb_regfile_dbg_arbiter;
  import rf_arb_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wdata;
  logic [4:0]  core_rs1;
  logic        core_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_rs1;
  logic [31:0] rf_rdata1;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_write;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  state_t      fsm_state;

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  regfile_dbg_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .core_rs1(core_rs1), .core_stall(core_stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_rs1(rf_rs1),
    .rf_rdata1(rf_rdata1),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata), .fsm_state(fsm_state)
  );

  // Register file: x0 reads zero and ignores writes.
  logic [31:0] rf_mem [32] = '{default: 32'd0};
  always @(posedge clk) if (rf_we && rf_rd != 5'd0) rf_mem[rf_rd] <= rf_wdata;
  assign rf_rdata1 = (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [32];
  logic [31:0] exp_q [$];   // expected debug responses, in order

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : exp_mem[a];
  endfunction

  // ---------------- core driver ----------------
  logic        cur_we;
  logic [4:0]  cur_rd;
  logic [31:0] cur_wdata;
  logic [4:0]  cur_rs1;
  int          we_mode;   // 0 random, 1 always write, 2 never write
  logic [4:0]  avoid_rd;  // core never targets this register (0 = none)

  task automatic new_instr();
    case (we_mode)
      1:       cur_we = 1'b1;
      2:       cur_we = 1'b0;
      default: cur_we = 1'($urandom_range(0, 1));
    endcase
    do cur_rd = 5'($urandom_range(0, 31));
    while (avoid_rd != 5'd0 && cur_rd == avoid_rd);
    cur_wdata = $urandom;
    cur_rs1   = 5'($urandom_range(0, 31));
  endtask

  task automatic drive_core();
    core_we    = cur_we;
    core_rd    = cur_rd;
    core_wdata = cur_wdata;
    core_rs1   = cur_rs1;
  endtask

  // One clock: a non-stalled instruction retires (its write lands in the
  // golden image) and the core moves on; a stalled one is replayed.
  task automatic tick(input bit stalled);
    @(posedge clk);
    if (!stalled) begin
      if (cur_we && cur_rd != 5'd0) exp_mem[cur_rd] = cur_wdata;
      new_instr();
    end
    #1;
    drive_core();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) rst_n = 1'b1;
      #1;
      total++;
      if ({fsm_state == IDLE, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, core_stall}
          !== {1'b1, 1'b1, 1'b0, 32'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset_outputs: idle=%0b req_ready=%0b rsp_valid=%0b rdata=%h stall=%0b, need 1 1 0 0 0",
                 fsm_state == IDLE, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, core_stall);
      end
      total++;
      if ({rf_we, rf_rd, rf_wdata, rf_rs1} !== {cur_we, cur_rd, cur_wdata, cur_rs1}) begin
        bad++;
        $display("FAIL reset_passthru: got we=%0b rd=%0d wd=%h rs1=%0d need we=%0b rd=%0d wd=%h rs1=%0d",
                 rf_we, rf_rd, rf_wdata, rf_rs1, cur_we, cur_rd, cur_wdata, cur_rs1);
      end
      tick(1'b0);
    end
  endtask

  task automatic test_read(input logic [4:0] addr, input int hold, input bit collide);
    logic [31:0] exp_data;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b0;
    dbg_req_addr  = addr;
    dbg_req_wdata = $urandom;
    dbg_rsp_ready = 1'b0;
    #1;
    total++;
    if (dbg_req_ready !== 1'b1 || core_stall !== 1'b0) begin
      bad++;
      $display("FAIL rd_accept: req_ready=%0b stall=%0b, need 1 0", dbg_req_ready, core_stall);
    end
    tick(1'b0);
    dbg_req_valid = 1'b0;
    if (collide) begin
      cur_we = 1'b1; cur_rd = addr; cur_wdata = 32'h0000_AAAA;
      drive_core();
    end
    #1;
    exp_data = exp_rd(addr);
    exp_q.push_back(exp_data);
    total++;
    if ({core_stall, rf_rs1, rf_we, dbg_req_ready, dbg_rsp_valid}
        !== {1'b1, addr, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rd_steal x%0d: stall=%0b rs1=%0d we=%0b req_ready=%0b rsp_valid=%0b, need 1 %0d 0 0 0",
               addr, core_stall, rf_rs1, rf_we, dbg_req_ready, dbg_rsp_valid, addr);
    end
    tick(1'b1);
    exp_data = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      // A competing request during the response must not be taken.
      dbg_req_valid = (i < hold);
      dbg_req_addr  = 5'($urandom_range(0, 31));
      dbg_rsp_ready = (i == hold);
      #1;
      total++;
      if ({dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready, core_stall}
          !== {1'b1, exp_data, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL rd_rsp x%0d cyc%0d: valid=%0b rdata=%h req_ready=%0b stall=%0b, need 1 %h 0 0",
                 addr, i, dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready, core_stall, exp_data);
      end
      tick(1'b0);
    end
    dbg_req_valid = 1'b0;
    dbg_rsp_ready = 1'b0;
    #1;
    total++;
    if ({dbg_rsp_valid, dbg_req_ready, rf_we, rf_rd, rf_wdata, rf_rs1}
        !== {1'b0, 1'b1, cur_we, cur_rd, cur_wdata, cur_rs1}) begin
      bad++;
      $display("FAIL rd_done: rsp_valid=%0b req_ready=%0b we=%0b rd=%0d rs1=%0d, need 0 1 %0b %0d %0d",
               dbg_rsp_valid, dbg_req_ready, rf_we, rf_rd, rf_rs1, cur_we, cur_rd, cur_rs1);
    end
  endtask

  task automatic test_write(input logic [4:0] addr, input logic [31:0] data, input int hold);
    bit granted;
    bit stl;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b1;
    dbg_req_addr  = addr;
    dbg_req_wdata = data;
    dbg_rsp_ready = 1'b0;
    #1;
    total++;
    if (dbg_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_accept: req_ready=%0b need 1", dbg_req_ready);
    end
    tick(1'b0);
    dbg_req_valid = 1'b0;
    granted = 1'b0;
    // Waited-cycle count n: the write goes in on the first idle core cycle,
    // or unconditionally once it has waited MAX_WAIT cycles.
    for (int n = 0; n <= MAX_WAIT && !granted; n++) begin
      #1;
      if (!cur_we || n == MAX_WAIT) begin
        total++;
        if ({rf_we, rf_rd, rf_wdata, core_stall, dbg_rsp_valid}
            !== {1'b1, addr, data, cur_we, 1'b0}) begin
          bad++;
          $display("FAIL wr_grant x%0d n=%0d: we=%0b rd=%0d wd=%h stall=%0b rsp_valid=%0b, need 1 %0d %h %0b 0",
                   addr, n, rf_we, rf_rd, rf_wdata, core_stall, dbg_rsp_valid, addr, data, cur_we);
        end
        stl = cur_we;
        tick(stl);
        if (addr != 5'd0) exp_mem[addr] = data;
        granted = 1'b1;
      end else begin
        total++;
        if ({rf_we, rf_rd, rf_wdata, rf_rs1, core_stall, dbg_rsp_valid}
            !== {cur_we, cur_rd, cur_wdata, cur_rs1, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL wr_wait x%0d n=%0d: we=%0b rd=%0d wd=%h stall=%0b rsp_valid=%0b, need %0b %0d %h 0 0",
                   addr, n, rf_we, rf_rd, rf_wdata, core_stall, dbg_rsp_valid, cur_we, cur_rd, cur_wdata);
        end
        tick(1'b0);
      end
    end
    for (int i = 0; i <= hold; i++) begin
      dbg_rsp_ready = (i == hold);
      #1;
      total++;
      if ({dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready, core_stall}
          !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL wr_rsp x%0d cyc%0d: valid=%0b rdata=%h req_ready=%0b stall=%0b, need 1 0 0 0",
                 addr, i, dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready, core_stall);
      end
      tick(1'b0);
    end
    dbg_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid(input logic [4:0] addr, input logic [31:0] data);
    we_mode  = 1;
    avoid_rd = addr;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b1;
    dbg_req_addr  = addr;
    dbg_req_wdata = data;
    dbg_rsp_ready = 1'b1;
    #1;
    tick(1'b0);
    dbg_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 2 + MAX_WAIT + 3; i++) begin
      if (i == 2) begin
        rst_n   = 1'b1;
        we_mode = 2;
      end
      #1;
      total++;
      if ({dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready, core_stall, rf_we, rf_rd, rf_wdata}
          !== {1'b0, 32'd0, 1'b1, 1'b0, cur_we, cur_rd, cur_wdata}) begin
        bad++;
        $display("FAIL rst_mid cyc%0d: rsp_valid=%0b rdata=%h req_ready=%0b stall=%0b we=%0b rd=%0d, need 0 0 1 0 %0b %0d",
                 i, dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready, core_stall, rf_we, rf_rd, cur_we, cur_rd);
      end
      tick(1'b0);
    end
    dbg_rsp_ready = 1'b0;
    we_mode = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        test_write(a, $urandom, int'($urandom_range(0, 3)));
      else
        test_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  // Read every register through the core's rs1 pass-through path.
  task automatic test_scan();
    we_mode = 2;
    for (int i = 0; i < 32; i++) begin
      cur_rs1 = 5'(i);
      drive_core();
      #1;
      total++;
      if (rf_rdata1 !== exp_rd(5'(i))) begin
        bad++;
        $display("FAIL scan x%0d: got %h need %h", i, rf_rdata1, exp_rd(5'(i)));
      end
      tick(1'b0);
    end
    we_mode = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
    we_mode  = 0;
    avoid_rd = 5'd0;
    dbg_req_valid = 1'b0;
    dbg_req_write = 1'b0;
    dbg_req_addr  = 5'd0;
    dbg_req_wdata = 32'd0;
    dbg_rsp_ready = 1'b0;
    rst_n = 1'b0;
    new_instr();
    drive_core();

    test_reset();

    // x5 <- DEADBEEF, then read it while the core runs.
    avoid_rd = 5'd5;
    test_write(5'd5, 32'hDEAD_BEEF, 0);
    test_read(5'd5, 0, 1'b0);

    // Write with an idle core: immediate grant, no stall.
    we_mode  = 2;
    avoid_rd = 5'd7;
    test_write(5'd7, 32'h0BAD_F00D, 0);

    // Write against a continuously writing core: forced after MAX_WAIT.
    we_mode = 1;
    test_write(5'd7, 32'h1234_5678, 0);
    we_mode = 0;
    test_read(5'd7, 0, 1'b0);

    // Read colliding with a core write to the same register, then readback.
    avoid_rd = 5'd3;
    test_read(5'd3, 0, 1'b1);
    test_read(5'd3, 0, 1'b0);

    // Response back-pressure for 10 cycles.
    avoid_rd = 5'd5;
    test_read(5'd5, 10, 1'b0);
    test_write(5'd5, 32'h5555_0000, 10);

    // Address 0.
    avoid_rd = 5'd0;
    test_write(5'd0, 32'hFFFF_FFFF, 0);
    test_read(5'd0, 0, 1'b0);

    // Reset while a write is pending; target must be unchanged afterwards.
    test_reset_mid(5'd9, 32'hCAFE_F00D);
    test_read(5'd9, 0, 1'b0);

    avoid_rd = 5'd0;
    test_random();
    test_scan();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
